// File: rtl/conv_mac_array_if.sv
// Beat/weight/result bus of the convolution dot-product engine.
// master drives beats and weights; slave is the engine that returns one result per group.
interface conv_mac_array_if #(
  parameter int unsigned LANES = 32,
  parameter int unsigned DW    = 4,
  parameter int unsigned ACC_W = 16
);
  logic                  weight_valid;
  logic [LANES*DW-1:0]   weight_in;
  logic                  in_valid;
  logic                  in_last;
  logic [LANES*DW-1:0]   ifm_in;
  logic                  relu_en;
  logic                  out_valid;
  logic [ACC_W-1:0]      out_ofm;
  logic                  out_ovf;
  logic                  out_err;

  modport master (
    output weight_valid, weight_in, in_valid, in_last, ifm_in, relu_en,
    input  out_valid, out_ofm, out_ovf, out_err
  );

  modport slave (
    input  weight_valid, weight_in, in_valid, in_last, ifm_in, relu_en,
    output out_valid, out_ofm, out_ovf, out_err
  );
endinterface

// File: rtl/conv_mac_array.sv
// Fully pipelined LANES-wide dot-product engine: multiply, two-stage registered
// adder tree, saturating group accumulator with ReLU and MAX_BEATS forced close.
module conv_mac_array #(
  parameter int unsigned LANES     = 32,
  parameter int unsigned DW        = 4,
  parameter int unsigned SIGNED    = 0,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic            clk,
  input  logic            rst,
  conv_mac_array_if.slave bus
);
  localparam int unsigned PW   = 2 * DW;
  localparam int unsigned SW   = PW + $clog2(LANES);
  localparam int unsigned HALF = LANES / 2;
  localparam int unsigned AW1  = ACC_W + 1;
  localparam int unsigned CW   = $clog2(MAX_BEATS + 1);
  localparam bit          SGN  = (SIGNED != 0);

  typedef enum logic {IDLE, ACC} state_e;

  typedef struct packed {
    logic valid;
    logic last;
    logic relu;
  } tag_t;

  // Operands are widened to the product width first so the truncated product is exact.
  function automatic logic [PW-1:0] lane_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [PW-1:0] ax;
    logic [PW-1:0] bx;
    ax = PW'(a);
    bx = PW'(b);
    if (SGN && a[DW-1]) ax = ax | ~PW'({DW{1'b1}});
    if (SGN && b[DW-1]) bx = bx | ~PW'({DW{1'b1}});
    return ax * bx;
  endfunction

  function automatic logic [SW-1:0] ext_pair(input logic [PW:0] p);
    logic [SW-1:0] r;
    r = SW'(p);
    if (SGN && p[PW]) r = r | ~SW'({(PW+1){1'b1}});
    return r;
  endfunction

  logic [LANES*DW-1:0] w_q, w_d;
  logic [PW-1:0]       prod_q [LANES];
  logic [PW-1:0]       prod_d [LANES];
  logic [PW:0]         pair_q [HALF];
  logic [PW:0]         pair_d [HALF];
  logic [SW-1:0]       sum3_q, sum3_d;
  tag_t                tag1_q, tag1_d, tag2_q, tag3_q;

  state_e              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                close4_q, close4_d;
  logic                err4_q, err4_d;
  logic                ovf4_q, ovf4_d;
  logic                relu4_q, relu4_d;

  logic                out_valid_q, out_valid_d;
  logic [ACC_W-1:0]    out_ofm_q, out_ofm_d;
  logic                out_ovf_q, out_ovf_d;
  logic                out_err_q, out_err_d;

  logic [AW1-1:0]      sum_x, acc_x, total;
  logic [ACC_W-1:0]    sat_val;
  logic                sat_hit;
  logic                first_beat;
  logic [CW-1:0]       beats;
  logic                force_close;
  logic                grp_ovf;

  // A same-edge weight load only affects the following beats: S1 reads w_q.
  always_comb begin
    w_d = bus.weight_valid ? bus.weight_in : w_q;
    for (int k = 0; k < LANES; k++) begin
      prod_d[k] = lane_mul(bus.ifm_in[k*DW +: DW], w_q[k*DW +: DW]);
    end
    tag1_d.valid = bus.in_valid;
    tag1_d.last  = bus.in_valid & bus.in_last;
    tag1_d.relu  = bus.relu_en;
  end

  always_comb begin
    for (int i = 0; i < HALF; i++) begin
      pair_d[i] = {SGN & prod_q[2*i][PW-1], prod_q[2*i]}
                + {SGN & prod_q[2*i+1][PW-1], prod_q[2*i+1]};
    end
  end

  always_comb begin
    sum3_d = '0;
    for (int i = 0; i < HALF; i++) begin
      sum3_d = sum3_d + ext_pair(pair_q[i]);
    end
  end

  // One extra bit of headroom makes the overflow test a simple top-bit check.
  always_comb begin
    sum_x = AW1'(sum3_q);
    if (SGN && sum3_q[SW-1]) sum_x = sum_x | ~AW1'({SW{1'b1}});
    acc_x   = {SGN & acc_q[ACC_W-1], acc_q};
    total   = acc_x + sum_x;
    sat_hit = 1'b0;
    sat_val = total[ACC_W-1:0];
    if (SGN) begin
      if (total[ACC_W] != total[ACC_W-1]) begin
        sat_hit = 1'b1;
        sat_val = total[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
    end else if (total[ACC_W]) begin
      sat_hit = 1'b1;
      sat_val = '1;
    end
  end

  // Group control: the first beat loads, later beats add; a close drains the sticky flags.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    close4_d    = 1'b0;
    err4_d      = 1'b0;
    ovf4_d      = 1'b0;
    relu4_d     = 1'b0;
    first_beat  = (state_q == IDLE);
    beats       = first_beat ? CW'(1) : cnt_q + CW'(1);
    force_close = ~tag3_q.last && (beats == CW'(MAX_BEATS));
    grp_ovf     = first_beat ? 1'b0 : (ovf_q | sat_hit);
    if (tag3_q.valid) begin
      acc_d = first_beat ? sum_x[ACC_W-1:0] : sat_val;
      if (tag3_q.last || force_close) begin
        state_d  = IDLE;
        cnt_d    = '0;
        ovf_d    = 1'b0;
        close4_d = 1'b1;
        err4_d   = force_close;
        ovf4_d   = grp_ovf;
        relu4_d  = tag3_q.relu;
      end else begin
        state_d = ACC;
        cnt_d   = beats;
        ovf_d   = grp_ovf;
      end
    end
  end

  always_comb begin
    out_valid_d = close4_q;
    out_ofm_d   = '0;
    out_ovf_d   = close4_q & ovf4_q;
    out_err_d   = close4_q & err4_q;
    if (close4_q) begin
      out_ofm_d = (SGN && relu4_q && acc_q[ACC_W-1]) ? '0 : acc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q <= '0;
      for (int k = 0; k < LANES; k++) prod_q[k] <= '0;
      for (int i = 0; i < HALF; i++) pair_q[i] <= '0;
      sum3_q      <= '0;
      tag1_q      <= '0;
      tag2_q      <= '0;
      tag3_q      <= '0;
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      close4_q    <= 1'b0;
      err4_q      <= 1'b0;
      ovf4_q      <= 1'b0;
      relu4_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_ofm_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      w_q <= w_d;
      for (int k = 0; k < LANES; k++) prod_q[k] <= prod_d[k];
      for (int i = 0; i < HALF; i++) pair_q[i] <= pair_d[i];
      sum3_q      <= sum3_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag1_q;
      tag3_q      <= tag2_q;
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      close4_q    <= close4_d;
      err4_q      <= err4_d;
      ovf4_q      <= ovf4_d;
      relu4_q     <= relu4_d;
      out_valid_q <= out_valid_d;
      out_ofm_q   <= out_ofm_d;
      out_ovf_q   <= out_ovf_d;
      out_err_q   <= out_err_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ofm   = out_ofm_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_err   = out_err_q;

endmodule

// File: tb/tb_conv_mac_array.sv
// Scoreboard bench for conv_mac_array: an unsigned and a signed instance share clk/rst,
// directed beats push hand-computed results, a negedge monitor pops and compares.
module tb_conv_mac_array;
  localparam int unsigned LANES     = 32;
  localparam int unsigned DW        = 4;
  localparam int unsigned ACC_W     = 16;
  localparam int unsigned MAX_BEATS = 16;

  typedef struct {
    string            name;
    logic [ACC_W-1:0] ofm;
    logic             ovf;
    logic             err;
    int               cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t q_u[$];
  exp_t q_s[$];

  conv_mac_array_if #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) bus_u ();
  conv_mac_array_if #(.LANES(LANES), .DW(DW), .ACC_W(ACC_W)) bus_s ();

  conv_mac_array #(.LANES(LANES), .DW(DW), .SIGNED(0), .ACC_W(ACC_W), .MAX_BEATS(MAX_BEATS))
    u_dut_u (.clk(clk), .rst(rst), .bus(bus_u));
  conv_mac_array #(.LANES(LANES), .DW(DW), .SIGNED(1), .ACC_W(ACC_W), .MAX_BEATS(MAX_BEATS))
    u_dut_s (.clk(clk), .rst(rst), .bus(bus_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Result is due 5 negedges after the negedge the closing beat is driven on.
  task automatic push(input int sel, input string name, input int ofm, input int ovf, input int err);
    exp_t e;
    e.name = name;
    e.ofm  = ACC_W'(ofm);
    e.ovf  = (ovf != 0);
    e.err  = (err != 0);
    e.cyc  = cyc + 5;
    if (sel != 0) q_s.push_back(e);
    else          q_u.push_back(e);
  endtask

  task automatic drive(input int sel, input int iv, input int il, input int ifm,
                       input int rl, input int wv, input int w);
    logic [DW-1:0] e;
    logic [DW-1:0] we;
    e  = DW'(ifm);
    we = DW'(w);
    bus_u.in_valid = 1'b0; bus_u.in_last = 1'b0; bus_u.relu_en = 1'b0;
    bus_u.weight_valid = 1'b0; bus_u.ifm_in = '0; bus_u.weight_in = '0;
    bus_s.in_valid = 1'b0; bus_s.in_last = 1'b0; bus_s.relu_en = 1'b0;
    bus_s.weight_valid = 1'b0; bus_s.ifm_in = '0; bus_s.weight_in = '0;
    if (sel == 0) begin
      bus_u.in_valid = (iv != 0); bus_u.in_last = (il != 0); bus_u.relu_en = (rl != 0);
      bus_u.weight_valid = (wv != 0); bus_u.ifm_in = {LANES{e}}; bus_u.weight_in = {LANES{we}};
    end else begin
      bus_s.in_valid = (iv != 0); bus_s.in_last = (il != 0); bus_s.relu_en = (rl != 0);
      bus_s.weight_valid = (wv != 0); bus_s.ifm_in = {LANES{e}}; bus_s.weight_in = {LANES{we}};
    end
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic mon(input int sel, input logic v, input logic [ACC_W-1:0] o,
                     input logic ovf, input logic err);
    exp_t  e;
    string who;
    who = (sel != 0) ? "s" : "u";
    checks++;
    if (v !== 1'b1) begin
      if (o !== '0) begin
        errors++;
        $display("FAIL idle_ofm_%s: got %0d want 0 at cyc %0d", who, o, cyc);
      end
    end else if (((sel != 0) ? q_s.size() : q_u.size()) == 0) begin
      errors++;
      $display("FAIL unexpected_out_%s: got ofm=%0d ovf=%0b err=%0b, want no output at cyc %0d",
               who, o, ovf, err, cyc);
    end else begin
      if (sel != 0) e = q_s.pop_front();
      else          e = q_u.pop_front();
      if (o !== e.ofm || ovf !== e.ovf || err !== e.err || cyc != e.cyc) begin
        errors++;
        $display("FAIL %s: got ofm=%0d ovf=%0b err=%0b cyc=%0d want ofm=%0d ovf=%0b err=%0b cyc=%0d",
                 e.name, o, ovf, err, cyc, e.ofm, e.ovf, e.err, e.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, bus_u.out_valid, bus_u.out_ofm, bus_u.out_ovf, bus_u.out_err);
    mon(1, bus_s.out_valid, bus_s.out_ofm, bus_s.out_ovf, bus_s.out_err);
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("reset_valid_u", int'(bus_u.out_valid), 0);
    chk("reset_ofm_u",   int'(bus_u.out_ofm),   0);
    chk("reset_ovf_u",   int'(bus_u.out_ovf),   0);
    chk("reset_err_u",   int'(bus_u.out_err),   0);
    chk("reset_valid_s", int'(bus_s.out_valid), 0);
    chk("reset_ofm_s",   int'(bus_s.out_ofm),   0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);

    // 32 * 15 * 15, latency 4 clocks from the sampling edge
    drive(0, 0, 0, 0, 0, 1, 15);
    push(0, "single_15x15", 7200, 0, 0);
    drive(0, 1, 1, 15, 0, 0, 0);

    // three beats of 32*2, then back-to-back single beat 32*3*2
    drive(0, 0, 0, 0, 0, 1, 2);
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    push(0, "three_beat", 192, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);
    push(0, "back_to_back", 192, 0, 0);
    drive(0, 1, 1, 3, 0, 0, 0);

    // bubble with a stray in_last in the middle of a group
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    push(0, "bubble_group", 128, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);

    // 10 * 7200 = 72000 clamps at 65535; next group is clean
    drive(0, 0, 0, 0, 0, 1, 15);
    for (int i = 0; i < 9; i++) drive(0, 1, 0, 15, 0, 0, 0);
    push(0, "unsigned_sat", 65535, 1, 0);
    drive(0, 1, 1, 15, 0, 0, 0);
    push(0, "after_sat", 480, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);

    // weight load on the same edge as a beat uses the old weights
    drive(0, 0, 0, 0, 0, 1, 1);
    push(0, "same_edge_old_w", 32, 0, 0);
    drive(0, 1, 1, 1, 0, 1, 3);
    push(0, "same_edge_new_w", 96, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);

    // 16 beats without last are force-closed; the next beat opens a new group
    drive(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 15; i++) drive(0, 1, 0, 1, 0, 0, 0);
    push(0, "max_beats", 512, 0, 1);
    drive(0, 1, 0, 1, 0, 0, 0);
    push(0, "after_max_beats", 32, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);

    // signed: 32 * 7 * -8 = -1792, ReLU clamps it, positive passes untouched
    drive(1, 0, 0, 0, 0, 1, 7);
    push(1, "signed_neg", 16'hF900, 0, 0);
    drive(1, 1, 1, -8, 0, 0, 0);
    push(1, "relu_neg", 0, 0, 0);
    drive(1, 1, 1, -8, 1, 0, 0);
    push(1, "relu_pos", 1568, 0, 0);
    drive(1, 1, 1, 7, 1, 0, 0);

    // signed: 16 * 2048 = 32768 clamps to 32767, closed by last so no err
    drive(1, 0, 0, 0, 0, 1, -8);
    for (int i = 0; i < 15; i++) drive(1, 1, 0, -8, 0, 0, 0);
    push(1, "signed_sat", 32767, 1, 0);
    drive(1, 1, 1, -8, 0, 0, 0);

    for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 0, 0, 0);

    // reset on the third beat (which carries last) discards the whole group
    drive(0, 1, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 1, 0, 0, 0);
    rst = 1'b1;
    drive(0, 1, 1, 1, 0, 0, 0);
    rst = 1'b0;
    chk("midgrp_rst_valid", int'(bus_u.out_valid), 0);
    chk("midgrp_rst_ofm",   int'(bus_u.out_ofm),   0);
    chk("midgrp_rst_ovf",   int'(bus_u.out_ovf),   0);
    chk("midgrp_rst_err",   int'(bus_u.out_err),   0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0, 0, 0, 0);
    push(0, "rst_cleared_w", 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 2);
    push(0, "after_rst", 64, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      if (q_u.size() == 0 && q_s.size() == 0) break;
      drive(0, 0, 0, 0, 0, 0, 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (q_u.size() != 0 || q_s.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d results outstanding want 0/0", q_u.size(), q_s.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_mac_array.md
Name: conv_mac_array

Overview:
Parametrised, fully pipelined dot-product engine for the convolution datapath. Each beat multiplies LANES IFM elements by LANES stored weights, reduces the products through a registered adder tree, and accumulates beats until the caller marks the last beat of a group. It produces one OFM value per group, with optional signed arithmetic, ReLU and saturation. It supersedes the fixed 32-lane, single-beat, unsigned convolution block.

Parameters:
LANES, 32, number of multiply lanes (power of 2, 2..64)
DW, 4, bit width of each IFM and weight element
SIGNED, 0, 0 = unsigned operands; 1 = two's-complement operands
ACC_W, 16, accumulator and output width (must be at least 2*DW+clog2(LANES))
MAX_BEATS, 16, maximum beats per group before the group is forced closed

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
weight_valid  in  1  load weight_in into the weight register this edge
weight_in  in  LANES*DW  packed weights; lane k occupies bits [k*DW +: DW]
in_valid  in  1  IFM beat valid
in_last  in  1  beat is the last of its group (qualified by in_valid)
ifm_in  in  LANES*DW  packed IFM elements, same packing as weight_in
relu_en  in  1  clamp negative results to 0 (no effect when SIGNED=0); sampled with the last beat
out_valid  out  1  one-cycle pulse marking a valid result
out_ofm  out  ACC_W  result; 0 whenever out_valid=0
out_ovf  out  1  result saturated; qualified by out_valid
out_err  out  1  group closed by MAX_BEATS rather than in_last; qualified by out_valid

Behaviour:
- Reset (rst=1 at an edge): clears weights, all pipeline registers, accumulator, beat counter and tag pipeline. out_valid=0, out_ofm=0, out_ovf=0, out_err=0. A group in flight is discarded with no output. Reset overrides every other input.
- Weight register: loads on weight_valid.
- Same-edge weight_valid and in_valid: the beat multiplies by the OLD weights; the new weights apply from the next beat.
- Pipeline: the beat is sampled at edge E0. Processing is one beat per clock with no bubbles or backpressure.
  - S1 (E0): LANES products, 2*DW bits each, signed if SIGNED=1.
  - S2 (E1): pairwise sums, 2*DW+1 bits.
  - S3 (E2): remaining tree reduction, 2*DW+clog2(LANES) bits, exact with no truncation.
  - S4 (E3): accumulate into ACC_W, sign-extended when SIGNED=1.
  - Output register (E4): out_valid is high during the cycle after E4 for the closing beat.
- Valid/last/relu tags travel in a shift pipeline alongside the data. Beats with in_valid=0 create bubbles that leave the accumulator untouched.
- Accumulator control is a two-state FSM:
  - IDLE: no open group.
  - ACC: group open.
  - IDLE -> ACC on a tagged valid beat without last.
  - ACC -> IDLE on a closing beat.
  - A single-beat group (valid and last together) passes IDLE -> IDLE and emits a result.
  - The first beat of a group loads the accumulator (acc = sum) rather than adding to it.
- Beat counter:
  - Counts beats in the open group.
  - When the MAX_BEATS-th beat arrives without in_last, it is treated as last: result emitted, out_err=1.
  - The next beat starts a new group.
- Saturation:
  - Unsigned: clamps to 2^ACC_W-1.
  - Signed: clamps to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Any clamp within the group sets a sticky ovf flag, reported on out_ovf and cleared when the group closes.
- ReLU: applied at the output register when SIGNED=1 and the closing beat's relu_en=1. It does not set out_ovf.
- Back-to-back groups: the closing beat of one group and the first beat of the next may be consecutive. The accumulator never mixes groups.
- in_last with in_valid=0 is ignored.

Test Plan:
- SIGNED=0: load all weights=15; one beat with all ifm=15 and in_last=1 -> out_valid pulses exactly 4 clocks after the sampling edge; out_ofm=7200, out_ovf=0, out_err=0.
- SIGNED=0: weights=2; three consecutive beats with ifm=1, in_last on the third -> single out_valid pulse, out_ofm=192. Follow immediately with a one-beat group of ifm=3 -> next-cycle pulse with out_ofm=192.
- SIGNED=0, ACC_W=16: ten beats of all-15 x all-15 -> out_ofm=65535, out_ovf=1. The next group of one beat with ifm=1, weights=15 -> 480, out_ovf=0.
- SIGNED=1: weights=7, ifm=-8 for one last beat -> out_ofm=-1792 (0xF900). Repeat with relu_en=1 -> out_ofm=0, out_ovf=0.
- Assert weight_valid with weights=3 on the same edge as a last beat of ifm=1 against old weights=1 -> out_ofm=32. The next beat with ifm=1 -> 96.
- Run 16 valid beats with no in_last (MAX_BEATS=16) -> output emitted with out_err=1. Separately, assert rst during the third beat of a group -> no out_valid, all outputs 0, and the next single-beat group computes correctly.
